// File: rtl/sort_frame_serializer.sv
// Captures one sorted frame from the insertion sorting array and streams it out word by word on valid/ready.
// Define SORT_FRAME_SERIALIZER_PREFETCH_EN to add a second frame buffer for back-to-back frames without bubbles.
module sort_frame_serializer #(
  parameter int SIZE  = 16,
  parameter int WIDTH = 32,
  parameter int IDXW  = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  input  logic [SIZE*WIDTH-1:0] frame_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WIDTH-1:0]      m_data,
  output logic [IDXW-1:0]       m_index,
  output logic                  m_last,
  output logic                  busy,
  output logic [15:0]           frames_done
);

  typedef enum logic {IDLE, STREAM} state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SIZE - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] act_reg [SIZE];
  logic [WIDTH-1:0] in_word [SIZE];
  logic [WIDTH-1:0] m_data_reg;
  logic [WIDTH-1:0] first_word;
  logic [IDXW-1:0]  idx_reg, idx_inc;
  logic             m_last_reg;
  logic [15:0]      frames_done_reg;
  logic             capture, hs, last_hs, load_new, start_frame;

  genvar gi;
  generate
    for (gi = 0; gi < SIZE; gi++) begin : g_split
      assign in_word[gi] = frame_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign capture = frame_valid & frame_ready;
  assign hs      = m_valid & m_ready;
  assign last_hs = hs & m_last_reg;
  assign idx_inc = idx_reg + IDXW'(1);

`ifdef SORT_FRAME_SERIALIZER_PREFETCH_EN
  logic [WIDTH-1:0] pend_reg [SIZE];
  logic             pending_reg, load_pend, load_from_pend;

  // A frame offered while the active one drains parks in the pending buffer,
  // unless it arrives on the last handshake, when it can go straight to active.
  assign load_new       = capture & ((state_reg == IDLE) | last_hs);
  assign load_pend      = capture & (state_reg == STREAM) & ~last_hs;
  assign load_from_pend = last_hs & pending_reg;
  assign start_frame    = load_new | load_from_pend;
  assign first_word     = load_from_pend ? pend_reg[0] : in_word[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_reg <= 1'b0;
    end else if (load_pend) begin
      pending_reg <= 1'b1;
    end else if (load_from_pend) begin
      pending_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < SIZE; k++) begin
      if (load_from_pend) begin
        act_reg[k] <= pend_reg[k];
      end else if (load_new) begin
        act_reg[k] <= in_word[k];
      end
      if (load_pend) begin
        pend_reg[k] <= in_word[k];
      end
    end
  end
`else
  assign load_new    = capture;
  assign start_frame = capture;
  assign first_word  = in_word[0];

  always_ff @(posedge clk) begin
    for (int k = 0; k < SIZE; k++) begin
      if (load_new) begin
        act_reg[k] <= in_word[k];
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (capture) state_next = STREAM;
      STREAM: if (last_hs && !start_frame) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    m_valid = (state_reg == STREAM);
`ifdef SORT_FRAME_SERIALIZER_PREFETCH_EN
    frame_ready = ~pending_reg;
    busy        = (state_reg == STREAM) | pending_reg;
`else
    frame_ready = (state_reg == IDLE);
    busy        = (state_reg == STREAM);
`endif
  end

  // Output word is registered so it holds steady across consumer stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_data_reg      <= '0;
      idx_reg         <= '0;
      m_last_reg      <= 1'b0;
      frames_done_reg <= '0;
    end else begin
      if (start_frame) begin
        m_data_reg <= first_word;
        idx_reg    <= '0;
        m_last_reg <= (SIZE == 1);
      end else if (hs) begin
        if (m_last_reg) begin
          idx_reg    <= '0;
          m_last_reg <= 1'b0;
        end else begin
          idx_reg    <= idx_inc;
          m_data_reg <= act_reg[idx_inc];
          m_last_reg <= (idx_inc == LAST_IDX);
        end
      end
      if (last_hs) begin
        frames_done_reg <= frames_done_reg + 16'd1;
      end
    end
  end

  assign m_data      = m_data_reg;
  assign m_index     = idx_reg;
  assign m_last      = m_last_reg;
  assign frames_done = frames_done_reg;

endmodule

// File: tb/tb_sort_frame_serializer.sv
// Scoreboard bench for sort_frame_serializer: stimulus pushes expected words, a monitor pops on each handshake.
module tb_sort_frame_serializer;

  logic         clk = 1'b0;
  logic         rst;
  logic         frame_valid, frame_ready;
  logic [511:0] frame_data;
  logic         m_valid, m_ready, m_last, busy;
  logic [31:0]  m_data;
  logic [3:0]   m_index;
  logic [15:0]  frames_done;

  logic         fv2, fr2, mv2, mr2, ml2, busy2;
  logic [63:0]  fd2;
  logic [31:0]  md2;
  logic [0:0]   mi2;
  logic [15:0]  fdone2;

  always #5 clk = ~clk;

  sort_frame_serializer #(.SIZE(16), .WIDTH(32)) dut (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_data(frame_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_index(m_index), .m_last(m_last), .busy(busy), .frames_done(frames_done)
  );

  sort_frame_serializer #(.SIZE(2), .WIDTH(32)) dut2 (
    .clk(clk), .rst(rst), .frame_valid(fv2), .frame_ready(fr2),
    .frame_data(fd2), .m_valid(mv2), .m_ready(mr2), .m_data(md2),
    .m_index(mi2), .m_last(ml2), .busy(busy2), .frames_done(fdone2)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  i;
    logic        l;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_d;
  logic [3:0]  stall_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Monitor: pops one expected word per handshake and checks stall stability.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("stall_valid", {31'd0, m_valid}, 32'd1);
          chk("stall_data", m_data, stall_d);
          chk("stall_index", {28'd0, m_index}, {28'd0, stall_i});
        end
        if (m_valid && m_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word actual=%0h required=none", m_data);
          end else begin
            e = sb_q.pop_front();
            $display("word idx=%0d data=%08h last=%0b", m_index, m_data, m_last);
            chk("word_data", m_data, e.d);
            chk("word_index", {28'd0, m_index}, {28'd0, e.i});
            chk("word_last", {31'd0, m_last}, {31'd0, e.l});
          end
        end
        stall_prev = m_valid && !m_ready;
        stall_d    = m_data;
        stall_i    = m_index;
      end
    end
  end

  task automatic send_frame(input logic [31:0] base, input logic [31:0] step, input bit expect_it);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!frame_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!frame_ready) fail_now("frame_ready_wait");
    for (int k = 0; k < 16; k++) begin
      frame_data[k*32 +: 32] = base + k * step;
      if (expect_it) begin
        e.d = base + k * step;
        e.i = 4'(k);
        e.l = (k == 15);
        sb_q.push_back(e);
      end
    end
    frame_valid = 1'b1;
    @(posedge clk);
    #1 frame_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || sb_q.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (busy || sb_q.size() != 0) fail_now("wait_idle");
    #1;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pat;
    bit          done;
    int          n, cnt, lasts;
    pat = 32'b1011_0010_0111_0001_1100_1010_0110_1001;

    rst = 1'b0; frame_valid = 1'b0; frame_data = '0; m_ready = 1'b1;
    fv2 = 1'b0; fd2 = {32'd2, 32'd1}; mr2 = 1'b1;
    #12;
    chk("rst_frame_ready", {31'd0, frame_ready}, 32'd1);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    chk("rst_m_index", {28'd0, m_index}, 32'd0);
    chk("rst_m_last", {31'd0, m_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frames_done", {16'd0, frames_done}, 32'd0);
    chk("rst_dut2_ready", {31'd0, fr2}, 32'd1);
    @(negedge clk) rst = 1'b1;

    // 1: one frame, consumer always ready
    send_frame(32'd1, 32'd1, 1'b1);
    chk("t1_latency_valid", {31'd0, m_valid}, 32'd1);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk("t1_no_bubble", {31'd0, m_valid}, 32'd1);
    end
    @(posedge clk); #1;
    chk("t1_valid_drop", {31'd0, m_valid}, 32'd0);
    chk("t1_frame_ready", {31'd0, frame_ready}, 32'd1);
    chk("t1_frames_done", {16'd0, frames_done}, 32'd1);

    // 2: same frame with a stalling consumer
    done = 1'b0;
    fork
      begin
        send_frame(32'd1, 32'd1, 1'b1);
        wait_idle();
        done = 1'b1;
      end
      begin
        int j;
        j = 0;
        while (!done) begin
          m_ready = pat[j % 32];
          j++;
          @(posedge clk);
          #1;
        end
      end
    join
    m_ready = 1'b1;
    chk("t2_frames_done", {16'd0, frames_done}, 32'd2);

    // 3: frame offered during streaming
`ifndef SORT_FRAME_SERIALIZER_PREFETCH_EN
    send_frame(32'd1, 32'd1, 1'b1);
    @(negedge clk);
    chk("t3_not_ready", {31'd0, frame_ready}, 32'd0);
    for (int k = 0; k < 16; k++) frame_data[k*32 +: 32] = 32'hAAAA0000 + k;
    frame_valid = 1'b1;
    @(posedge clk);
    #1 frame_valid = 1'b0;
    wait_idle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t3_no_queued_frame", {31'd0, m_valid}, 32'd0);
    end
`else
    send_frame(32'd1, 32'd1, 1'b1);
    wait_idle();
`endif
    chk("t3_frames_done", {16'd0, frames_done}, 32'd3);

    // 4: asynchronous reset mid-stream
    send_frame(32'd1, 32'd1, 1'b1);
    n = 0;
    while (m_index != 4'd7 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t4_reach_idx7", {28'd0, m_index}, 32'd7);
    #2 rst = 1'b0;
    #1;
    chk("t4_async_valid", {31'd0, m_valid}, 32'd0);
    chk("t4_async_ready", {31'd0, frame_ready}, 32'd1);
    chk("t4_async_frames_done", {16'd0, frames_done}, 32'd0);
    chk("t4_async_index", {28'd0, m_index}, 32'd0);
    sb_q.delete();
    @(negedge clk) rst = 1'b1;
    send_frame(32'hFFFFFFFF, 32'd0, 1'b1);
    wait_idle();
    chk("t4_frames_done", {16'd0, frames_done}, 32'd1);

`ifdef SORT_FRAME_SERIALIZER_PREFETCH_EN
    // 6: back-to-back frames through the prefetch buffer
    send_frame(32'd1, 32'd1, 1'b1);
    lasts = 0;
    fork
      send_frame(32'd101, 32'd1, 1'b1);
      begin
        for (int c = 0; c < 32; c++) begin
          @(negedge clk);
          chk("t6_consecutive_valid", {31'd0, m_valid}, 32'd1);
          if (m_last) lasts++;
        end
      end
    join
    chk("t6_last_pulses", lasts, 32'd2);
    wait_idle();
    chk("t6_frames_done", {16'd0, frames_done}, 32'd3);
`endif

    // 5: frames_done wrap on a SIZE=2 instance
    fv2 = 1'b1;
    cnt = 0;
    n = 0;
    while (cnt < 65535 && n < 300000) begin
      @(negedge clk);
      if (mv2 && mr2 && ml2) cnt++;
      n++;
    end
    chk("t5_last_count", cnt, 32'd65535);
    @(posedge clk); #1;
    chk("t5_frames_done_max", {16'd0, fdone2}, 32'h0000FFFF);
    n = 0;
    @(negedge clk);
    while (!(mv2 && ml2) && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    fv2 = 1'b0;
    chk("t5_frames_done_wrap", {16'd0, fdone2}, 32'd0);

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
